// File: rtl/fifo_pkg.sv
// Types and constants shared between the team FIFO and its burst reader.
package fifo_pkg;

  localparam int unsigned WIDTH = 32;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StBurst
  } state_e;

endpackage

// File: rtl/fifo_out_stage.sv
// Single-entry valid/ready output register: load captures a word, ready drains it.
module fifo_out_stage #(
  parameter int unsigned WIDTH = fifo_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

  // A stalled word must not change or vanish before it is accepted.
  stall_stable_a : assert property (@(posedge clk) disable iff (!reset_n)
    (valid && !ready) |=> (valid && $stable(data)));

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a FIFO in bursts of up to BURST_LEN words once it has filled past its
// low threshold, or after TIMEOUT cycles of waiting for it to do so.
module fifo_burst_reader #(
  parameter int unsigned WIDTH     = fifo_pkg::WIDTH,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic             fifo_almost_empty,
  input  logic             fifo_error,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             burst_done,
  output logic [15:0]      words_read,
  output logic             err_sticky
);

  import fifo_pkg::*;

  localparam logic [4:0] BurstLenW = 5'(BURST_LEN);
  localparam logic [7:0] WaitLastW = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [4:0]  beat_q, beat_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] words_q, words_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        pop;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    words_d = words_q;
    done_d  = 1'b0;
    err_d   = err_q | fifo_error;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && !fifo_empty) begin
          state_d = StWait;
          wait_d  = '0;
        end
      end
      StWait: begin
        wait_d = wait_q + 8'd1;
        if (!enable) begin
          state_d = StIdle;
        end else if (!fifo_almost_empty || (wait_q == WaitLastW)) begin
          state_d = StBurst;
          beat_d  = '0;
        end
      end
      StBurst: begin
        pop = !fifo_empty && (beat_q < BurstLenW) && enable && (!out_valid || out_ready);
        if (pop) begin
          beat_d  = beat_q + 5'd1;
          words_d = words_q + 16'd1;
        end
        // The pop on this edge still completes; the burst ends after it.
        if ((pop && (beat_d == BurstLenW)) || (fifo_empty && !pop) || !enable) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      wait_q  <= '0;
      words_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      words_q <= words_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  fifo_out_stage #(
    .WIDTH(WIDTH)
  ) u_out_stage (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (pop),
    .ready  (out_ready),
    .data_in(fifo_data),
    .valid  (out_valid),
    .data   (out_data)
  );

  assign fifo_pop   = pop;
  assign burst_done = done_q;
  assign words_read = words_q;
  assign err_sticky = err_q;

  no_pop_on_empty_a : assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_pop && fifo_empty));

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter BURST_LEN, default 8, maximum pops per burst (range 1..16).
REQ-003 SHALL have parameter TIMEOUT, default 16, WAIT cycles before a short burst is forced (range 1..255).
REQ-004 SHALL have ports, with clock and reset first:
- clk  input  1  single clock, all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  permits new bursts.
- fifo_empty  input  1  FIFO empty flag.
- fifo_almost_empty  input  1  FIFO fill is at or below its low threshold.
- fifo_error  input  1  FIFO error flag.
- fifo_data  input  WIDTH  FIFO head word, combinational from the FIFO.
- fifo_pop  output  1  pop request to the FIFO.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  registered word.
- burst_done  output  1  one-cycle pulse when a burst ends.
- words_read  output  16  total pops, wraps modulo 2^16.
- err_sticky  output  1  latched fifo_error.

Function
REQ-005 SHALL implement a three-state FSM: IDLE, WAIT and BURST.
REQ-006 IDLE -> WAIT when enable=1 and fifo_empty=0.
REQ-007 WAIT SHALL increment an 8-bit wait counter each cycle.
- WAIT -> BURST when fifo_almost_empty=0, or when wait counter = TIMEOUT-1.
- WAIT -> IDLE when enable=0; this check takes priority.
- The wait counter clears on WAIT entry.
REQ-008 In BURST, fifo_pop SHALL equal fifo_empty=0 AND beat count < BURST_LEN AND enable=1 AND (out_valid=0 OR out_ready=1); fifo_pop is combinational.
REQ-009 fifo_pop SHALL be 0 in IDLE and WAIT, and SHALL never be 1 while fifo_empty=1.
REQ-010 On each pop edge:
- out_data <= fifo_data.
- out_valid <= 1.
- beat count increments.
- words_read increments.
- Word latency is one cycle from the pop cycle to out_data.
REQ-011 When out_valid=1 and out_ready=0, out_data and out_valid SHALL stay stable.
REQ-012 out_valid SHALL clear on an edge with out_ready=1 and no pop; a pop with out_ready=1 replaces the word back-to-back.
REQ-013 BURST SHALL end, going to IDLE with burst_done pulsing for one cycle, on the first edge where any of the following holds:
- beat count = BURST_LEN after the pop;
- fifo_empty=1 with no pop;
- enable=0.
REQ-014 Beat count SHALL clear on BURST entry and be 5 bits wide.
REQ-015 out_valid MAY remain 1 after a burst ends; IDLE SHALL still drain it via out_ready.
REQ-016 A new burst SHALL start only from IDLE, so there is at least one WAIT cycle between bursts.
REQ-017 err_sticky SHALL set on any edge with fifo_error=1 and hold until reset; fifo_error SHALL NOT alter pop behaviour.
REQ-018 Simultaneous pop and burst-end conditions SHALL complete the pop, then end the burst.

Reset
REQ-019 Asserting reset_n=0 SHALL immediately force:
- state IDLE;
- out_valid 0 and out_data 0;
- burst_done 0 and words_read 0 and err_sticky 0;
- beat count 0 and wait counter 0;
- fifo_pop 0.
REQ-020 Reset mid-burst SHALL discard the held word; no pop occurs in the first cycle after release.

Structure
REQ-021 Package fifo_pkg SHALL hold the following, shared with the FIFO:
- WIDTH;
- word_t;
- the FSM state enum.
REQ-022 The valid/ready output register SHALL be a sub-module named fifo_out_stage (load, ready, valid, data); the FSM and counters stay in fifo_burst_reader.
REQ-023 Pop-on-empty and out_data-stability-under-stall SHALL be embedded as concurrent assertions on posedge clk, disabled while reset_n=0.

Verification
REQ-024 Bench SHALL instance the team FIFO (depth 16, ALMOST_EMPTY=4) driving this block and cover these scenarios:
- Full burst: push 12 words 0x100..0x10B, enable=1, out_ready=1 -> 8 consecutive pops; out_data 0x100..0x107 each one cycle after its pop; burst_done once; words_read=8.
- Timeout: push 2 words, out_ready=1 -> exactly 16 WAIT cycles, then 2 pops; short burst ends on empty; burst_done once.
- Backpressure: 12 words queued, out_ready held 0 for 5 cycles mid-burst -> out_data stable, no pops while stalled; order preserved; no word lost or duplicated.
- Enable drop: enable=0 after the 3rd pop -> no 4th pop; IDLE next edge; held word still delivered after out_ready=1.
- Reset mid-burst: reset_n=0 after the 4th pop -> all outputs 0 immediately; after release, the remaining FIFO words are read in order on the next burst.
- Error latch: pulse fifo_error for 1 cycle -> err_sticky=1 until reset; pop pattern unchanged.
